// File: rtl/first_counter.sv
// Free-running WIDTH-bit up-counter with count enable and wrap-around.
// Latency: one clock from enable sampled high to the incremented counter_out.
// No backpressure: counts whenever enabled; reset clears asynchronously.
//
// Ports:
//   clock       - system clock; count state changes on the rising edge only
//   reset       - asynchronous active-high clear; holds the count at 0 while high
//   enable      - count enable, sampled on the rising edge of clock
//   counter_out - current count, driven straight from the count register
module first_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // Natural modulo-2^WIDTH arithmetic gives the wrap from all-ones to zero.
  assign w_count_nxt = r_count + ONE;

  // Reset is in the sensitivity list, so it wins over enable at every edge and
  // also clears the count between edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_count_nxt;
    end
  end

  // Output comes straight off the register: no combinational path from enable.
  assign counter_out = r_count;

endmodule

// File: tb/tb_first_counter.sv
module tb_first_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] counter_out;

  int n_vec;
  int n_err;
  int model;   // reference count as a plain integer in [0, MOD)

  first_counter #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out)
  );

  // First rising edge at t=10, falling edges at 5, 15, 25, ...
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                           input int exp);
    logic [WIDTH-1:0] e;
    e = exp[WIDTH-1:0];
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL %s: got %0d (%b), expected %0d at t=%0t", tag, obs, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs are set at the falling edge, the model follows the
  // counter's rules at the rising edge, and the output is checked at the next
  // falling edge.
  task automatic step(input logic rst, input logic en, input string tag);
    reset  = rst;
    enable = en;
    @(posedge clock);
    if (rst)     model = 0;
    else if (en) model = (model + 1) % MOD;
    @(negedge clock);
    check_val(tag, counter_out, model);
  endtask

  // Reset pulse placed midway between edges; the clear must be visible before
  // the next rising edge.
  task automatic async_clear(input string tag);
    reset = 1'b1;
    #1;
    model = 0;
    check_val(tag, counter_out, model);
    #2;
    reset = 1'b0;
    #1;
    check_val({tag, "_rel"}, counter_out, model);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    model  = 0;
    reset  = 1'b0;
    enable = 1'b0;

    // Reset clears: asserted at t=5, released at t=15.
    #5 reset = 1'b1;
    #1 check_val("rst_async", counter_out, 0);
    @(negedge clock);                     // t=15
    check_val("rst_held", counter_out, 0);
    reset = 1'b0;
    model = 0;
    step(1'b0, 1'b0, "idle_t25");          // edge at 20, enable low

    // Count run: enable high from t=25 to t=125, edges 30..120.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "count_run");
    check_val("count_reach10", counter_out, 10);

    // Hold: enable low from t=125.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold");
    check_val("hold_10", counter_out, 10);

    // Wrap: clear, then 17 enabled edges giving 1..15, 0, 1.
    async_clear("wrap_clr");
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, "wrap_seq");
    check_val("wrap_17th", counter_out, 1);

    // Asynchronous reset at count 7.
    async_clear("mid_pre");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "mid_count");
    check_val("mid_at7", counter_out, 7);
    async_clear("mid_clr");
    step(1'b0, 1'b1, "mid_resume");
    check_val("mid_resume1", counter_out, 1);

    // Reset priority over enable across several edges.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "rst_prio");
    step(1'b0, 1'b1, "prio_release");

    // Randomised run: enable random, occasional held or mid-cycle reset.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 31);
      if (r == 0)      async_clear("rnd_async");
      else if (r == 1) step(1'b1, 1'($urandom_range(0, 1)), "rnd_rst");
      else             step(1'b0, 1'($urandom_range(0, 3) != 0), "rnd_cnt");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion by t=100000");
    $fatal(1);
  end

endmodule
